kt_run_seq: RTL and testbench

//  Run/stop and console-operation sequencer for the console (KT) block. Consumes the latched

---
 rtl/kt_run_seq_if.sv | 45 ++++
 rtl/kt_run_seq.sv | 182 ++++++++++++++++++
 tb/tb_kt_run_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/kt_run_seq_if.sv
// Console sequencer bus: latched console flops and timing strobes in, run/console controls out.
interface kt_run_seq_if;
    localparam int unsigned CODE_W = 8;

    // console latch and timing generator side
    logic              i_ktqq;
    logic [CODE_W-1:0] i_zlkt;
    logic              i_ls;
    logic              i_tbtj;
    logic              i_dp;
    logic              i_dzq;
    logic              i_dzl;
    logic              i_pai_end;
    logic              i_cyc_end;
    logic              i_ins_end;
    logic              i_kt_ack;

    // sequencer results
    logic              o_yx;
    logic              o_ktzt;
    logic              o_kt_go;
    logic [CODE_W-1:0] o_kt_code;
    logic              o_kt_done;
    logic              o_kt_err;
    logic              o_z0ktqq;
    logic              o_z0ls;
    logic              o_z0tbtj;
    logic              o_z0dp;
    logic              o_z0dzq;
    logic              o_z0dzl;

    modport master (
        output i_ktqq, i_zlkt, i_ls, i_tbtj, i_dp, i_dzq, i_dzl,
               i_pai_end, i_cyc_end, i_ins_end, i_kt_ack,
        input  o_yx, o_ktzt, o_kt_go, o_kt_code, o_kt_done, o_kt_err,
               o_z0ktqq, o_z0ls, o_z0tbtj, o_z0dp, o_z0dzq, o_z0dzl
    );

    modport slave (
        input  i_ktqq, i_zlkt, i_ls, i_tbtj, i_dp, i_dzq, i_dzl,
               i_pai_end, i_cyc_end, i_ins_end, i_kt_ack,
        output o_yx, o_ktzt, o_kt_go, o_kt_code, o_kt_done, o_kt_err,
               o_z0ktqq, o_z0ls, o_z0tbtj, o_z0dp, o_z0dzq, o_z0dzl
    );
endinterface

// File: rtl/kt_run_seq.sv
// Run/stop and console-operation sequencer for the KT console block.
// Every output is the registered image of what the current state decides,
// so each reaction appears one clock after the cycle that caused it.
module kt_run_seq #(
    parameter int unsigned      TMO_W    = 8,
    parameter logic [TMO_W-1:0] TMO_MAX  = TMO_W'(200),
    parameter logic [7:0]       QDZ_CODE = 8'hFB
) (
    input  logic        clk,
    input  logic        t_rst0,
    kt_run_seq_if.slave bus
);
    localparam int unsigned CODE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KT_GO   = 3'd1,
        S_KT_EXEC = 3'd2,
        S_KT_DONE = 3'd3,
        S_RUN     = 3'd4,
        S_STOP    = 3'd5
    } state_t;

    // which single-step flop (if any) bounds the current run
    typedef enum logic [1:0] {
        M_CONT = 2'd0,
        M_DP   = 2'd1,
        M_DZQ  = 2'd2,
        M_DZL  = 2'd3
    } mode_t;

    state_t            r_state,   w_state;
    mode_t             r_mode,    w_mode;
    logic [TMO_W-1:0]  r_wdog,    w_wdog;
    logic [CODE_W-1:0] r_kt_code, w_kt_code;
    logic              r_kt_err,  w_kt_err;
    logic              r_yx,      w_yx;
    logic              r_ktzt,    w_ktzt;
    logic              r_kt_go,   w_kt_go;
    logic              r_kt_done, w_kt_done;
    logic              r_z0ktqq,  w_z0ktqq;
    logic              r_z0ls,    w_z0ls;
    logic              r_z0tbtj,  w_z0tbtj;
    logic              r_z0dp,    w_z0dp;
    logic              r_z0dzq,   w_z0dzq;
    logic              r_z0dzl,   w_z0dzl;
    logic              w_stop_hit;

    // any armed boundary condition ends the run; simultaneous hits collapse into one stop
    assign w_stop_hit = ((r_mode == M_DP)  && bus.i_pai_end) ||
                        ((r_mode == M_DZQ) && bus.i_cyc_end) ||
                        ((r_mode == M_DZL) && bus.i_ins_end) ||
                        (bus.i_tbtj        && bus.i_ins_end);

    // next-state and next-output decisions
    always_comb begin
        w_state   = r_state;
        w_mode    = r_mode;
        w_wdog    = r_wdog;
        w_kt_code = r_kt_code;
        w_kt_err  = r_kt_err;
        w_yx      = (r_state == S_RUN);
        w_ktzt    = (r_state == S_KT_GO) || (r_state == S_KT_EXEC) || (r_state == S_KT_DONE);
        w_kt_go   = 1'b0;
        w_kt_done = 1'b0;
        w_z0ktqq  = 1'b0;
        w_z0ls    = 1'b0;
        w_z0tbtj  = 1'b0;
        w_z0dp    = 1'b0;
        w_z0dzq   = 1'b0;
        w_z0dzl   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // a console request takes precedence over a start arriving the same cycle
                if (bus.i_ktqq) begin
                    w_state = S_KT_GO;
                end else if (bus.i_ls) begin
                    w_state = S_RUN;
                    w_z0ls  = 1'b1;
                    if (bus.i_dp)       w_mode = M_DP;
                    else if (bus.i_dzq) w_mode = M_DZQ;
                    else if (bus.i_dzl) w_mode = M_DZL;
                    else                w_mode = M_CONT;
                end
            end
            S_KT_GO: begin
                w_kt_code = bus.i_zlkt;
                w_kt_go   = 1'b1;
                w_wdog    = '0;
                w_kt_err  = 1'b0;
                w_state   = S_KT_EXEC;
            end
            S_KT_EXEC: begin
                // an ack on the expiry cycle still counts as a clean completion
                if (bus.i_kt_ack) begin
                    w_state = S_KT_DONE;
                end else if (r_wdog == TMO_MAX) begin
                    w_kt_err = 1'b1;
                    w_state  = S_KT_DONE;
                end else begin
                    w_wdog = r_wdog + TMO_W'(1);
                end
            end
            S_KT_DONE: begin
                w_z0ktqq  = 1'b1;
                w_kt_done = 1'b1;
                if ((r_kt_code == QDZ_CODE) && !r_kt_err) begin
                    w_state = S_RUN;
                    w_mode  = M_CONT;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_stop_hit) w_state = S_STOP;
            end
            S_STOP: begin
                // clear the flop that armed this stop, plus the sync-stop flop if it is set
                unique case (r_mode)
                    M_DP:    w_z0dp  = 1'b1;
                    M_DZQ:   w_z0dzq = 1'b1;
                    M_DZL:   w_z0dzl = 1'b1;
                    default: ;
                endcase
                w_z0tbtj = bus.i_tbtj;
                w_state  = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    // state, datapath and output registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge t_rst0) begin
        if (t_rst0) begin
            r_state   <= S_IDLE;
            r_mode    <= M_CONT;
            r_wdog    <= '0;
            r_kt_code <= '0;
            r_kt_err  <= 1'b0;
            r_yx      <= 1'b0;
            r_ktzt    <= 1'b0;
            r_kt_go   <= 1'b0;
            r_kt_done <= 1'b0;
            r_z0ktqq  <= 1'b0;
            r_z0ls    <= 1'b0;
            r_z0tbtj  <= 1'b0;
            r_z0dp    <= 1'b0;
            r_z0dzq   <= 1'b0;
            r_z0dzl   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_mode    <= w_mode;
            r_wdog    <= w_wdog;
            r_kt_code <= w_kt_code;
            r_kt_err  <= w_kt_err;
            r_yx      <= w_yx;
            r_ktzt    <= w_ktzt;
            r_kt_go   <= w_kt_go;
            r_kt_done <= w_kt_done;
            r_z0ktqq  <= w_z0ktqq;
            r_z0ls    <= w_z0ls;
            r_z0tbtj  <= w_z0tbtj;
            r_z0dp    <= w_z0dp;
            r_z0dzq   <= w_z0dzq;
            r_z0dzl   <= w_z0dzl;
        end
    end

    assign bus.o_yx      = r_yx;
    assign bus.o_ktzt    = r_ktzt;
    assign bus.o_kt_go   = r_kt_go;
    assign bus.o_kt_code = r_kt_code;
    assign bus.o_kt_done = r_kt_done;
    assign bus.o_kt_err  = r_kt_err;
    assign bus.o_z0ktqq  = r_z0ktqq;
    assign bus.o_z0ls    = r_z0ls;
    assign bus.o_z0tbtj  = r_z0tbtj;
    assign bus.o_z0dp    = r_z0dp;
    assign bus.o_z0dzq   = r_z0dzq;
    assign bus.o_z0dzl   = r_z0dzl;
endmodule

// File: tb/tb_kt_run_seq.sv
// Self-checking bench for kt_run_seq: per-cycle vector table plus hand-built console sequences.
module tb_kt_run_seq;
    // input bit positions: ktqq ls tbtj dp dzq dzl pai cyc ins ack
    localparam logic [9:0] I_KTQQ = 10'h200;
    localparam logic [9:0] I_LS   = 10'h100;
    localparam logic [9:0] I_TBTJ = 10'h080;
    localparam logic [9:0] I_DP   = 10'h040;
    localparam logic [9:0] I_DZQ  = 10'h020;
    localparam logic [9:0] I_DZL  = 10'h010;
    localparam logic [9:0] I_PAI  = 10'h008;
    localparam logic [9:0] I_CYC  = 10'h004;
    localparam logic [9:0] I_INS  = 10'h002;
    localparam logic [9:0] I_ACK  = 10'h001;

    // output bit positions: yx ktzt go done err z0ktqq z0ls z0tbtj z0dp z0dzq z0dzl
    localparam logic [10:0] F_YX    = 11'h400;
    localparam logic [10:0] F_KTZT  = 11'h200;
    localparam logic [10:0] F_GO    = 11'h100;
    localparam logic [10:0] F_DONE  = 11'h080;
    localparam logic [10:0] F_ERR   = 11'h040;
    localparam logic [10:0] F_Z0KT  = 11'h020;
    localparam logic [10:0] F_Z0LS  = 11'h010;
    localparam logic [10:0] F_Z0TB  = 11'h008;
    localparam logic [10:0] F_Z0DP  = 11'h004;
    localparam logic [10:0] F_Z0DZQ = 11'h002;
    localparam logic [10:0] F_Z0DZL = 11'h001;
    localparam logic [10:0] F_NONE  = 11'h000;

    typedef struct {
        logic [9:0]  in;
        logic [7:0]  zlkt;
        logic [10:0] exp;
        logic [7:0]  code;
    } vec_t;

    typedef struct {
        logic [10:0] flags;
        logic [7:0]  code;
        string       name;
    } exp_t;

    logic clk;
    logic t_rst0;
    int   n_pass;
    int   n_total;
    vec_t tbl[$];
    exp_t sb_q[$];

    kt_run_seq_if bus ();

    kt_run_seq dut (
        .clk    (clk),
        .t_rst0 (t_rst0),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [10:0] act_flags();
        return {bus.o_yx, bus.o_ktzt, bus.o_kt_go, bus.o_kt_done, bus.o_kt_err,
                bus.o_z0ktqq, bus.o_z0ls, bus.o_z0tbtj, bus.o_z0dp, bus.o_z0dzq, bus.o_z0dzl};
    endfunction

    task automatic compare(input string nm, input logic [10:0] ef, input logic [7:0] ec);
        logic [10:0] af;
        af = act_flags();
        n_total++;
        if (af === ef && bus.o_kt_code === ec) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got flags=%b code=%h, want flags=%b code=%h",
                     nm, af, bus.o_kt_code, ef, ec);
        end
    endtask

    task automatic drive(input logic [9:0] in, input logic [7:0] zlkt);
        {bus.i_ktqq, bus.i_ls, bus.i_tbtj, bus.i_dp, bus.i_dzq, bus.i_dzl,
         bus.i_pai_end, bus.i_cyc_end, bus.i_ins_end, bus.i_kt_ack} = in;
        bus.i_zlkt = zlkt;
    endtask

    // drive one cycle of stimulus, queue its expected result, compare once the edge has passed
    task automatic apply(input logic [9:0] in, input logic [7:0] zlkt,
                         input logic [10:0] exp, input logic [7:0] code, input string nm);
        exp_t e;
        drive(in, zlkt);
        e.flags = exp;
        e.code  = code;
        e.name  = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        compare(e.name, e.flags, e.code);
    endtask

    task automatic add(input logic [9:0] in, input logic [7:0] zlkt,
                       input logic [10:0] exp, input logic [7:0] code);
        vec_t v;
        v.in   = in;
        v.zlkt = zlkt;
        v.exp  = exp;
        v.code = code;
        tbl.push_back(v);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        t_rst0  = 1'b1;
        drive(10'h000, 8'h00);

        // single-beat run; an early cycle-end must not stop it
        add(I_LS | I_DP,  8'h00, F_Z0LS, 8'h00);
        add(I_CYC | I_DP, 8'h00, F_YX,   8'h00);
        add(I_PAI,        8'h00, F_YX,   8'h00);
        add(10'h000,      8'h00, F_Z0DP, 8'h00);
        add(10'h000,      8'h00, F_NONE, 8'h00);
        // DZQ wins priority over DZL; triple stop hit gives a single stop; strobes in IDLE ignored
        add(I_LS | I_DZQ | I_DZL,           8'h00, F_Z0LS,           8'h00);
        add(I_INS | I_PAI | I_DZQ,          8'h00, F_YX,             8'h00);
        add(I_CYC | I_INS | I_TBTJ,         8'h00, F_YX,             8'h00);
        add(I_TBTJ,                         8'h00, F_Z0TB | F_Z0DZQ, 8'h00);
        add(I_TBTJ | I_INS | I_PAI | I_CYC, 8'h00, F_NONE,           8'h00);
        // single-instruction run
        add(I_LS | I_DZL, 8'h00, F_Z0LS,  8'h00);
        add(I_INS,        8'h00, F_YX,    8'h00);
        add(10'h000,      8'h00, F_Z0DZL, 8'h00);
        add(10'h000,      8'h00, F_NONE,  8'h00);
        // continuous run: console request ignored, only sync stop at instruction end halts
        add(I_LS,                          8'h00, F_Z0LS, 8'h00);
        add(I_KTQQ | I_LS | I_PAI | I_CYC, 8'h00, F_YX,   8'h00);
        add(I_TBTJ,                        8'h00, F_YX,   8'h00);
        add(I_TBTJ | I_INS,                8'h00, F_YX,   8'h00);
        add(I_TBTJ,                        8'h00, F_Z0TB, 8'h00);
        add(10'h000,                       8'h00, F_NONE, 8'h00);
        // request and start together: console op first, start honoured afterwards
        add(I_KTQQ | I_LS,         8'h9F, F_NONE,                    8'h00);
        add(I_KTQQ | I_LS,         8'h9F, F_KTZT | F_GO,             8'h9F);
        add(I_KTQQ | I_LS,         8'h9F, F_KTZT,                    8'h9F);
        add(I_KTQQ | I_LS | I_ACK, 8'h9F, F_KTZT,                    8'h9F);
        add(I_KTQQ | I_LS,         8'h9F, F_KTZT | F_DONE | F_Z0KT,  8'h9F);
        add(I_LS,                  8'h9F, F_Z0LS,                    8'h9F);
        add(I_TBTJ | I_INS,        8'h9F, F_YX,                      8'h9F);
        add(I_TBTJ,                8'h9F, F_Z0TB,                    8'h9F);
        add(10'h000,               8'h9F, F_NONE,                    8'h9F);
        // start-instruction code enters RUN straight from KT_DONE
        add(I_KTQQ,         8'hFB, F_NONE,                   8'h9F);
        add(I_KTQQ,         8'hFB, F_KTZT | F_GO,            8'hFB);
        add(I_ACK,          8'hFB, F_KTZT,                   8'hFB);
        add(10'h000,        8'hFB, F_KTZT | F_DONE | F_Z0KT, 8'hFB);
        add(I_PAI | I_CYC,  8'hFB, F_YX,                     8'hFB);
        add(I_TBTJ | I_INS, 8'hFB, F_YX,                     8'hFB);
        add(I_TBTJ,         8'hFB, F_Z0TB,                   8'hFB);
        add(10'h000,        8'hFB, F_NONE,                   8'hFB);

        repeat (2) @(posedge clk);
        #1;
        compare("reset_state", F_NONE, 8'h00);
        t_rst0 = 1'b0;
        apply(10'h000, 8'h00, F_NONE, 8'h00, "post_reset_idle");

        foreach (tbl[i])
            apply(tbl[i].in, tbl[i].zlkt, tbl[i].exp, tbl[i].code, $sformatf("tbl[%0d]", i));

        // watchdog expiry, sticky error, cleared by the next request
        apply(I_KTQQ, 8'h11, F_NONE, 8'hFB, "tmo_go");
        apply(I_KTQQ, 8'h11, F_KTZT | F_GO, 8'h11, "tmo_exec");
        for (int i = 0; i < 200; i++)
            apply(I_KTQQ, 8'h11, F_KTZT, 8'h11, $sformatf("tmo_wait%0d", i));
        apply(I_KTQQ, 8'h11, F_KTZT | F_ERR, 8'h11, "tmo_expire");
        apply(10'h000, 8'h11, F_KTZT | F_ERR | F_DONE | F_Z0KT, 8'h11, "tmo_done");
        apply(10'h000, 8'h11, F_ERR, 8'h11, "tmo_err_sticky");
        apply(I_KTQQ, 8'h9F, F_ERR, 8'h11, "tmo_next_go");
        apply(I_KTQQ, 8'h9F, F_KTZT | F_GO, 8'h9F, "tmo_err_clear");
        apply(I_ACK, 8'h9F, F_KTZT, 8'h9F, "tmo_next_ack");
        apply(10'h000, 8'h9F, F_KTZT | F_DONE | F_Z0KT, 8'h9F, "tmo_next_done");
        apply(10'h000, 8'h9F, F_NONE, 8'h9F, "tmo_next_idle");

        // ack arriving on the expiry cycle wins over the watchdog
        apply(I_KTQQ, 8'h9F, F_NONE, 8'h9F, "edge_go");
        apply(I_KTQQ, 8'h9F, F_KTZT | F_GO, 8'h9F, "edge_exec");
        for (int i = 0; i < 200; i++)
            apply(I_KTQQ, 8'h9F, F_KTZT, 8'h9F, $sformatf("edge_wait%0d", i));
        apply(I_KTQQ | I_ACK, 8'h9F, F_KTZT, 8'h9F, "edge_ack");
        apply(10'h000, 8'h9F, F_KTZT | F_DONE | F_Z0KT, 8'h9F, "edge_done_noerr");
        apply(10'h000, 8'h9F, F_NONE, 8'h9F, "edge_idle");

        // ack five cycles after go
        apply(I_KTQQ, 8'h9F, F_NONE, 8'h9F, "ack5_go");
        apply(I_KTQQ, 8'h9F, F_KTZT | F_GO, 8'h9F, "ack5_exec");
        for (int i = 0; i < 5; i++)
            apply(I_KTQQ, 8'h9F, F_KTZT, 8'h9F, $sformatf("ack5_wait%0d", i));
        apply(I_ACK, 8'h9F, F_KTZT, 8'h9F, "ack5_ack");
        apply(10'h000, 8'h9F, F_KTZT | F_DONE | F_Z0KT, 8'h9F, "ack5_done");
        apply(10'h000, 8'h9F, F_NONE, 8'h9F, "ack5_idle");

        // reset in the middle of a console op: everything drops, no clear pulse follows
        apply(I_KTQQ, 8'h55, F_NONE, 8'h9F, "rst_go");
        apply(I_KTQQ, 8'h55, F_KTZT | F_GO, 8'h55, "rst_exec");
        apply(I_KTQQ, 8'h55, F_KTZT, 8'h55, "rst_exec2");
        drive(10'h000, 8'h55);
        t_rst0 = 1'b1;
        #1;
        compare("rst_async", F_NONE, 8'h00);
        @(posedge clk);
        #1;
        compare("rst_hold", F_NONE, 8'h00);
        t_rst0 = 1'b0;
        apply(10'h000, 8'h55, F_NONE, 8'h00, "rst_no_z0ktqq");
        apply(10'h000, 8'h55, F_NONE, 8'h00, "rst_idle");
        apply(I_LS | I_DP, 8'h00, F_Z0LS, 8'h00, "rst_recover_run");
        apply(I_PAI, 8'h00, F_YX, 8'h00, "rst_recover_stop");
        apply(10'h000, 8'h00, F_Z0DP, 8'h00, "rst_recover_z0dp");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
